// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// The arbiter drives grants, owner and hold_cnt; the masters drive their requests.
interface bus_arbiter_if #(
  parameter int HOLD_W = 5
) ();
  logic              m0_req;
  logic              m1_req;
  logic              m2_req;
  logic              m3_req;
  logic              m0_grant;
  logic              m1_grant;
  logic              m2_grant;
  logic              m3_grant;
  logic [1:0]        owner;
  logic [HOLD_W-1:0] hold_cnt;

  // Requester side: raises requests, observes grants and debug state
  modport master (
    output m0_req, m1_req, m2_req, m3_req,
    input  m0_grant, m1_grant, m2_grant, m3_grant, owner, hold_cnt
  );

  // Arbiter side: samples requests, drives registered grants and debug state
  modport slave (
    input  m0_req, m1_req, m2_req, m3_req,
    output m0_grant, m1_grant, m2_grant, m3_grant, owner, hold_cnt
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 4-master shared bus with a bounded tenure.
// Grants are a registered one-hot decode of the owner, so the bus always has
// exactly one grant, parks on the last owner when idle, and there is no
// combinational path from any request to any grant.
`ifndef GRANT_ENABLE
`define GRANT_ENABLE 1'b1
`endif

module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  // Last tenure count before a forced handover; unused when MAX_HOLD is 0
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  logic [1:0]        owner_reg;
  logic [1:0]        owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic [3:0]        grant_reg;
  logic [3:0]        grant_next;

  logic [3:0]        req_vec;
  logic [3:0]        rot_req;     // rot_req[d] = request of master owner+d (mod 4)
  logic              others_req;
  logic              rot_found;
  logic [1:0]        rot_dist;    // rotation distance of the next requester

  assign req_vec = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};

  // Requests re-indexed by distance from the current owner; bit 0 is the owner
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req_vec[owner_reg + 2'(gi)];
    end
  endgenerate

  assign others_req = |rot_req[3:1];

  // Nearest requester after the owner; the owner itself is considered last
  always_comb begin
    rot_found = 1'b1;
    rot_dist  = 2'd1;
    if (rot_req[1]) begin
      rot_dist = 2'd1;
    end else if (rot_req[2]) begin
      rot_dist = 2'd2;
    end else if (rot_req[3]) begin
      rot_dist = 2'd3;
    end else begin
      rot_found = 1'b0;
    end
  end

  // Next owner and tenure count from the current owner, its count and the requests
  always_comb begin
    owner_next    = owner_reg;
    hold_cnt_next = '0;
    if (rot_req[0]) begin
      if (others_req) begin
        if ((MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_LAST)) begin
          // Tenure used up under contention: pass the bus on
          owner_next = owner_reg + rot_dist;
        end else if (MAX_HOLD != 0) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
    end else if (rot_found) begin
      owner_next = owner_reg + rot_dist;
    end
  end

  // One-hot grant decode of the next owner, registered below
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grant
      assign grant_next[gi] = (owner_next == 2'(gi)) ? `GRANT_ENABLE : ~`GRANT_ENABLE;
    end
  endgenerate

  // State register; reset wins over any handover decided on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg    <= 2'd0;
      hold_cnt_reg <= '0;
      grant_reg    <= {{3{~`GRANT_ENABLE}}, `GRANT_ENABLE};
    end else begin
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.m0_grant = grant_reg[0];
    bus.m1_grant = grant_reg[1];
    bus.m2_grant = grant_reg[2];
    bus.m3_grant = grant_reg[3];
    bus.owner    = owner_reg;
    bus.hold_cnt = hold_cnt_reg;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (tenure limit 16 and limit disabled) share
// the same request stimulus; a reference model pushes expected owner/count/grant
// per cycle into a queue, popped and compared one cycle later.
module tb_bus_arbiter;

  localparam int HOLD_W = 5;

  typedef struct {
    int         own;
    int         hold;
    logic [3:0] grant;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_own[2];
  int   m_hold[2];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  bus_arbiter_if #(.HOLD_W(HOLD_W)) bus_a ();
  bus_arbiter_if #(.HOLD_W(HOLD_W)) bus_b ();

  bus_arbiter #(.MAX_HOLD(16), .HOLD_W(HOLD_W)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  bus_arbiter #(.MAX_HOLD(0), .HOLD_W(HOLD_W)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  // Reference model of one arbitration edge for instance u
  task automatic model_step(input int u, input int max_hold, input logic rst, input logic [3:0] req);
    int cur;
    int nxt;
    bit contend;
    bit found;
    if (rst) begin
      m_own[u]  = 0;
      m_hold[u] = 0;
      return;
    end
    cur     = m_own[u];
    contend = 1'b0;
    for (int k = 0; k < 4; k++)
      if (k != cur && req[k]) contend = 1'b1;
    found = 1'b0;
    nxt   = cur;
    for (int d = 1; d < 4; d++) begin
      if (!found && req[(cur + d) % 4]) begin
        found = 1'b1;
        nxt   = (cur + d) % 4;
      end
    end
    if (req[cur]) begin
      if (!contend) begin
        m_hold[u] = 0;
      end else if (max_hold != 0 && m_hold[u] == max_hold - 1) begin
        m_own[u]  = nxt;
        m_hold[u] = 0;
      end else if (max_hold != 0) begin
        m_hold[u] = m_hold[u] + 1;
      end else begin
        m_hold[u] = 0;
      end
    end else begin
      m_own[u]  = nxt;
      m_hold[u] = 0;
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic cycle(input logic rst, input logic [3:0] req);
    exp_t ea;
    exp_t eb;
    exp_t pa;
    exp_t pb;
    reset        = rst;
    bus_a.m0_req = req[0];
    bus_a.m1_req = req[1];
    bus_a.m2_req = req[2];
    bus_a.m3_req = req[3];
    bus_b.m0_req = req[0];
    bus_b.m1_req = req[1];
    bus_b.m2_req = req[2];
    bus_b.m3_req = req[3];
    model_step(0, 16, rst, req);
    model_step(1, 0, rst, req);
    ea.own   = m_own[0];
    ea.hold  = m_hold[0];
    ea.grant = 4'(1 << m_own[0]);
    eb.own   = m_own[1];
    eb.hold  = m_hold[1];
    eb.grant = 4'(1 << m_own[1]);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    n_txn++;
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    check_val("a_owner", 32'(bus_a.owner), 32'(pa.own));
    check_val("a_hold", 32'(bus_a.hold_cnt), 32'(pa.hold));
    check_val("a_grant", 32'({bus_a.m3_grant, bus_a.m2_grant, bus_a.m1_grant, bus_a.m0_grant}), 32'(pa.grant));
    check_val("b_owner", 32'(bus_b.owner), 32'(pb.own));
    check_val("b_hold", 32'(bus_b.hold_cnt), 32'(pb.hold));
    check_val("b_grant", 32'({bus_b.m3_grant, bus_b.m2_grant, bus_b.m1_grant, bus_b.m0_grant}), 32'(pb.grant));
    $display("txn %0d rst=%b req=%b a:own=%0d hold=%0d b:own=%0d hold=%0d",
             n_txn, rst, req, bus_a.owner, bus_a.hold_cnt, bus_b.owner, bus_b.hold_cnt);
  endtask

  initial begin
    logic [3:0] rq;

    // Reset, then idle: parked on master 0
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0000);
      check_val("idle_owner", 32'(bus_a.owner), 32'd0);
      check_val("idle_grant", 32'({bus_a.m3_grant, bus_a.m2_grant, bus_a.m1_grant, bus_a.m0_grant}), 32'h1);
    end

    // Single request from idle takes the bus one cycle later
    cycle(1'b0, 4'b0100);
    check_val("m2_owner", 32'(bus_a.owner), 32'd2);
    check_val("m2_grant", 32'({bus_a.m3_grant, bus_a.m2_grant, bus_a.m1_grant, bus_a.m0_grant}), 32'h4);

    // Rotation order on release, including wrap past master 3
    cycle(1'b0, 4'b0010);
    check_val("rot_to1", 32'(bus_a.owner), 32'd1);
    cycle(1'b0, 4'b1101);
    check_val("rot_1to2", 32'(bus_a.owner), 32'd2);
    cycle(1'b0, 4'b1001);
    check_val("rot_2to3", 32'(bus_a.owner), 32'd3);
    cycle(1'b0, 4'b0111);
    check_val("rot_wrap", 32'(bus_a.owner), 32'd0);

    // Two masters contending from reset: 16-cycle tenures vs. no limit
    cycle(1'b1, 4'b0011);
    for (int i = 0; i < 15; i++) cycle(1'b0, 4'b0011);
    check_val("ten_a_hold15", 32'(bus_a.hold_cnt), 32'd15);
    check_val("ten_a_own0", 32'(bus_a.owner), 32'd0);
    check_val("ten_b_hold0", 32'(bus_b.hold_cnt), 32'd0);
    cycle(1'b0, 4'b0011);
    check_val("ten_a_handover", 32'(bus_a.owner), 32'd1);
    check_val("ten_b_keep", 32'(bus_b.owner), 32'd0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 4'b0011);

    // Reset mid-tenure with owner 3 at count 9
    cycle(1'b1, 4'b1000);
    cycle(1'b0, 4'b1000);
    for (int i = 0; i < 9; i++) cycle(1'b0, 4'b1001);
    check_val("mid_own3", 32'(bus_a.owner), 32'd3);
    check_val("mid_hold9", 32'(bus_a.hold_cnt), 32'd9);
    cycle(1'b1, 4'b1001);
    check_val("rst_own0", 32'(bus_a.owner), 32'd0);
    check_val("rst_hold0", 32'(bus_a.hold_cnt), 32'd0);
    check_val("rst_grant", 32'({bus_a.m3_grant, bus_a.m2_grant, bus_a.m1_grant, bus_a.m0_grant}), 32'h1);

    // Fast-changing random requests with occasional reset
    for (int i = 0; i < 150; i++) begin
      rq = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 49) == 0, rq);
    end

    // Slowly changing requests so tenure limits are reached
    rq = 4'b1111;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) rq = 4'($urandom_range(0, 15));
      cycle(1'b0, rq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin bus arbiter for the 4-master shared bus.
- Samples the per-master request lines and produces the registered one-hot grants m0_grant..m3_grant.
- Those grants directly drive the bus master multiplexer that selects the winning master's addr/data/as/rw.
- Adds a bounded-tenure counter so that no master can starve the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles an owner keeps the bus while another master is requesting. 0 disables the limit.
- HOLD_W, 5: width of the tenure counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  bus request, master 0.
- m1_req  input  1  bus request, master 1.
- m2_req  input  1  bus request, master 2.
- m3_req  input  1  bus request, master 3.
- m0_grant  output  1  bus grant, master 0 (`GRANT_ENABLE when owner).
- m1_grant  output  1  bus grant, master 1.
- m2_grant  output  1  bus grant, master 2.
- m3_grant  output  1  bus grant, master 3.
- owner  output  2  index of the current bus owner.
- hold_cnt  output  HOLD_W  current tenure count, for debug/coverage.

Behaviour:
- State: owner register (2 bits) and hold_cnt register. Grants are a registered one-hot decode of owner.
- Exactly one grant is asserted in every cycle, including idle. The bus parks on the last owner.
- Reset (synchronous, highest priority):
  - owner=0, m0_grant=`GRANT_ENABLE, m1..m3_grant disabled, hold_cnt=0.
  - Reset asserted mid-tenure overrides any pending handover on that same edge.
- Latency: a decision uses the req values at edge N; the new grant is visible after edge N. So req→grant is 1 cycle, and a release→next-grant handover is 1 cycle with no idle gap.
- Owner requesting (req[owner]=1):
  - No other requests: owner kept, hold_cnt held at 0.
  - Others requesting, hold_cnt < MAX_HOLD-1: owner kept, hold_cnt increments by 1.
  - Others requesting, hold_cnt == MAX_HOLD-1 and MAX_HOLD != 0: forced handover to the next requester in rotation; hold_cnt=0. The owner therefore holds at most MAX_HOLD cycles under contention.
  - MAX_HOLD=0: never forced off; hold_cnt stays 0.
- Owner not requesting (req[owner]=0):
  - Search owner+1, owner+2, owner+3 (mod 4) in that order. The first master with req=1 becomes owner and hold_cnt=0.
  - If none is requesting, owner is unchanged (parked) and hold_cnt=0.
- Rotation wraps: after owner 3 the search order is 0, 1, 2.
- Simultaneous requests: resolved strictly by rotation distance from the current owner, never by fixed index.
- A master that loses the bus through the tenure limit while still requesting rejoins the rotation normally. It is considered last, because it is the previous owner.
- hold_cnt saturates logically through the limit compare and never wraps.
- No combinational path from req to grant.

Test Plan:
- Reset then all req=0 for 5 cycles → m0_grant=1, owner=0, hold_cnt=0 throughout.
- m2_req=1 from cycle 3 while owner 0 is idle → owner=2 and m2_grant=1 visible from cycle 4; m0_grant=0 from cycle 4.
- Owner 1 releases while m0_req, m2_req and m3_req are all 1 → owner=2 the next cycle. Owner 2 releases → owner=3. Owner 3 releases → owner=0 (wrap order verified).
- MAX_HOLD=16: m0_req and m1_req both held at 1 from reset → m0 granted exactly 16 cycles, then m1 for 16, alternating. hold_cnt runs 0..15 in each tenure.
- MAX_HOLD=0: same stimulus as the previous scenario → m0 is granted indefinitely and hold_cnt stays 0.
- reset asserted while owner=3 with hold_cnt=9 → next edge: owner=0, m0_grant=1, hold_cnt=0, regardless of req state.
